fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10, program-counter and instruction-address width in bits.
REQ-002 SHALL have parameter HALT_OP, default 4'd12, opcode driven to the controller whenever no instruction is valid.
REQ-003 SHALL have port CLK, input, 1: single clock, all state on the rising edge.
REQ-004 SHALL have port RST_N, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port START, input, 1: level-sampled; begins or restarts execution at START_ADDR.
REQ-006 SHALL have port START_ADDR, input, PC_W: entry address.
REQ-007 SHALL have port INSTR_IN, input, 9: instruction word returned combinationally by the instruction ROM for INSTR_ADDR.
REQ-008 SHALL have port BRANCH, input, 1: branch request from the controller.
REQ-009 SHALL have port BR_COND, input, 1: branch condition from the datapath flag logic.
REQ-010 SHALL have port BR_TARGET, input, PC_W: absolute branch target.
REQ-011 SHALL have port HALT, input, 1: halt request from the controller.
REQ-012 SHALL have port INSTR_ADDR, output, PC_W: current PC, drives the ROM address.
REQ-013 SHALL have port OPCODE, output, 4: opcode field feeding the controller.
REQ-014 SHALL have port OPERAND, output, 5: INSTR_IN[4:0].
REQ-015 SHALL have port VALID, output, 1: high when OPCODE/OPERAND carry a live instruction.
REQ-016 SHALL have port DONE, output, 1: high while halted.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and HALTED.
REQ-018 In IDLE: VALID=0, DONE=0, OPCODE=HALT_OP, OPERAND=0, PC held.
REQ-019 In IDLE with START=1: PC<=START_ADDR and next state RUN; the first instruction is valid in the following cycle.
REQ-020 In RUN: VALID=1, OPCODE=INSTR_IN[8:5], OPERAND=INSTR_IN[4:0].
REQ-021 Per-edge priority in RUN: START (PC<=START_ADDR, stay RUN) > HALT (PC held, next state HALTED) > BRANCH&&BR_COND (PC<=BR_TARGET) > PC<=PC+1.
REQ-022 BRANCH=1 with BR_COND=0 SHALL increment the PC.
REQ-023 The PC increment SHALL wrap modulo 2^PC_W (all-ones -> 0) with no flag.
REQ-024 In HALTED: DONE=1, VALID=0, OPCODE=HALT_OP, PC frozen at the halting instruction's address; BRANCH and HALT are ignored.
REQ-025 In HALTED with START=1: PC<=START_ADDR, DONE<=0, next state RUN.
REQ-026 All outputs except OPCODE/OPERAND (combinational from state and INSTR_IN) SHALL be registered; the PC update latency SHALL be exactly one cycle.
REQ-027 In IDLE and HALTED, HALT and BRANCH inputs SHALL have no effect.

Reset
REQ-028 RST_N=0 SHALL immediately force state IDLE, PC=0, DONE=0, VALID=0, OPCODE=HALT_OP, and ICOUNT=0 when present.
REQ-029 Reset asserted mid-RUN SHALL abandon the current instruction; after release, execution resumes only on START.

Configuration
REQ-030 With macro FETCH_ICOUNT_EN defined: add output ICOUNT, 16 bits, counting RUN cycles (instructions issued); it SHALL saturate at 16'hFFFF, clear on any accepted START, and hold in IDLE and HALTED.
REQ-031 Without FETCH_ICOUNT_EN: ICOUNT port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, START=1 with START_ADDR=5, then straight-line code -> INSTR_ADDR 5,6,7,... from the cycle after START, VALID=1.
REQ-033 At PC=8, BRANCH=1, BR_COND=1, BR_TARGET=20 -> next PC=20; same stimulus with BR_COND=0 -> next PC=9.
REQ-034 HALT=1 and BRANCH=1/BR_COND=1 on the same edge at PC=12 -> HALTED, PC stays 12, DONE=1, OPCODE=12; a later START with START_ADDR=0 -> RUN, PC=0, DONE=0.
REQ-035 PC=1023 with no branch -> next PC=0, VALID stays 1.
REQ-036 RST_N pulled low mid-RUN at PC=40 -> PC=0, IDLE, VALID=0 with no clock edge; with FETCH_ICOUNT_EN, ICOUNT=0.
REQ-037 With FETCH_ICOUNT_EN: run 70000 cycles without halting -> ICOUNT saturates at 65535; START -> ICOUNT=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_if
// Brief    : Bus between the fetch unit, its controller and the instruction ROM.
//            The icount member exists only when FETCH_ICOUNT_EN is defined.
// Revision : 1.0
// ============================================================================
interface fetch_if #(
  parameter int PC_W = 10
);
  logic            start;
  logic [PC_W-1:0] start_addr;
  logic [8:0]      instr_in;
  logic            branch;
  logic            br_cond;
  logic [PC_W-1:0] br_target;
  logic            halt;
  logic [PC_W-1:0] instr_addr;
  logic [3:0]      opcode;
  logic [4:0]      operand;
  logic            valid;
  logic            done;
`ifdef FETCH_ICOUNT_EN
  logic [15:0]     icount;
`endif

  modport slave (
`ifdef FETCH_ICOUNT_EN
    output icount,
`endif
    input  start, start_addr, instr_in, branch, br_cond, br_target, halt,
    output instr_addr, opcode, operand, valid, done
  );

  modport master (
`ifdef FETCH_ICOUNT_EN
    input  icount,
`endif
    output start, start_addr, instr_in, branch, br_cond, br_target, halt,
    input  instr_addr, opcode, operand, valid, done
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : PC sequencer with start/branch/halt control. Optional macro
//            FETCH_ICOUNT_EN adds a saturating 16-bit issued-instruction count.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter int         PC_W    = 10,
  parameter logic [3:0] HALT_OP = 4'd12
) (
  input  wire logic clk,
  input  wire logic rst_n,
  fetch_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] c_pc_one = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_valid;
  logic            r_done;
  logic [3:0]      w_opcode;
  logic [4:0]      w_operand;

`ifdef FETCH_ICOUNT_EN
  localparam logic [15:0] c_icount_max = 16'hFFFF;
  logic [15:0] r_icount;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
`ifdef FETCH_ICOUNT_EN
      r_icount <= '0;
`endif
    end else begin
      case (r_state)
        // Branch and halt are deliberately not looked at outside RUN.
        IDLE, HALTED: begin
          if (bus.start) begin
            r_state  <= RUN;
            r_pc     <= bus.start_addr;
            r_valid  <= 1'b1;
            r_done   <= 1'b0;
`ifdef FETCH_ICOUNT_EN
            r_icount <= '0;
`endif
          end
        end
        RUN: begin
          if (bus.start) begin
            r_pc     <= bus.start_addr;
`ifdef FETCH_ICOUNT_EN
            r_icount <= '0;
`endif
          end else begin
`ifdef FETCH_ICOUNT_EN
            if (r_icount != c_icount_max) begin
              r_icount <= r_icount + 16'd1;
            end
`endif
            // The halting instruction keeps its address so it stays visible.
            if (bus.halt) begin
              r_state <= HALTED;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else if (bus.branch && bus.br_cond) begin
              r_pc <= bus.br_target;
            end else begin
              r_pc <= r_pc + c_pc_one;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_opcode  = HALT_OP;
    w_operand = 5'd0;
    if (r_state == RUN) begin
      w_opcode  = bus.instr_in[8:5];
      w_operand = bus.instr_in[4:0];
    end
  end

  assign bus.instr_addr = r_pc;
  assign bus.opcode     = w_opcode;
  assign bus.operand    = w_operand;
  assign bus.valid      = r_valid;
  assign bus.done       = r_done;
`ifdef FETCH_ICOUNT_EN
  assign bus.icount     = r_icount;
`endif

endmodule
`default_nettype wire
